div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit_pkg.sv | 30 +++
 rtl/div_unit.sv | 142 ++++++++++++++
 tb/tb_div_unit.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared encodings for the iterative divider: op codes, FSM states and the step count.
package div_unit_pkg;

  localparam int unsigned RDATA_WIDTH = 32;
  localparam int unsigned DIV_CYCLES  = 32;

  typedef enum logic [1:0] {
    DivOpDiv  = 2'b00,
    DivOpDivu = 2'b01,
    DivOpRem  = 2'b10,
    DivOpRemu = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StOn   = 2'b01,
    StEnd  = 2'b10
  } div_state_e;

  // Bit 0 clear selects the signed variants (DIV, REM).
  function automatic logic op_is_signed(logic [1:0] op);
    return ~op[0];
  endfunction

  // Bit 1 set selects the remainder variants (REM, REMU).
  function automatic logic op_is_rem(logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_unit.sv
// Restoring radix-2 divider: one quotient bit per cycle, sign fix-up on the final step.
// ready_o is a registered one-cycle pulse held while the FSM sits in StEnd.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned DATA_W = RDATA_WIDTH
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  input  logic              annul_i,
  output logic [DATA_W-1:0] result_o,
  output logic              ready_o,
  output logic              busy_o
);

  localparam logic [5:0] LastStep = 6'(DIV_CYCLES - 1);

  div_state_e        state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              ready_q, ready_d;

  logic [DATA_W:0]   shifted, diff;
  logic [DATA_W-1:0] step_quo, step_rem, fin_quo, fin_rem;
  logic              a_neg, b_neg;

  always_comb begin
    shifted = {rem_q, quo_q[DATA_W-1]};
    diff    = shifted - {1'b0, dvs_q};
    if (!diff[DATA_W]) begin
      step_rem = diff[DATA_W-1:0];
      step_quo = {quo_q[DATA_W-2:0], 1'b1};
    end else begin
      step_rem = shifted[DATA_W-1:0];
      step_quo = {quo_q[DATA_W-2:0], 1'b0};
    end
    // Sign fix-up applies to the post-step values so the result lands with ready_o.
    fin_quo = (op_is_signed(op_q) && qneg_q) ? (~step_quo + 1'b1) : step_quo;
    fin_rem = (op_is_signed(op_q) && rneg_q) ? (~step_rem + 1'b1) : step_rem;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    ready_d  = 1'b0;
    a_neg    = op_is_signed(op_i) & dividend_i[DATA_W-1];
    b_neg    = op_is_signed(op_i) & divisor_i[DATA_W-1];

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          op_d   = op_i;
          quo_d  = a_neg ? (~dividend_i + 1'b1) : dividend_i;
          rem_d  = '0;
          dvs_d  = b_neg ? (~divisor_i + 1'b1) : divisor_i;
          qneg_d = a_neg ^ b_neg;
          rneg_d = a_neg;
          cnt_d  = '0;
          if (divisor_i == '0) begin
            state_d  = StEnd;
            ready_d  = 1'b1;
            result_d = op_is_rem(op_i) ? dividend_i : '1;
          end else begin
            state_d = StOn;
          end
        end
      end
      StOn: begin
        quo_d = step_quo;
        rem_d = step_rem;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LastStep) begin
          state_d  = StEnd;
          ready_d  = 1'b1;
          result_d = op_is_rem(op_q) ? fin_rem : fin_quo;
        end
      end
      StEnd: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A flush wins over everything, including a start in the same cycle.
    if (annul_i) begin
      state_d  = StIdle;
      ready_d  = 1'b0;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = (state_q != StIdle);

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: hand-computed quotients/remainders, latency, annul and async reset.
module tb_div_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        annul_i;
  logic [31:0] result_o;
  logic        ready_o;
  logic        busy_o;

  int checks   = 0;
  int failures = 0;

  div_unit #(.DATA_W(32)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .op_i       (op_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .annul_i    (annul_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accept at the next edge, scramble inputs, count edges until ready_o, then check drain.
  task automatic run_div(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int n;
    start_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b;
    @(posedge clk_i); #1;
    start_i = 1'b0; op_i = ~op; dividend_i = 32'hDEAD_BEEF; divisor_i = 32'h0;
    n = 0;
    while (!ready_o && n < 40) begin
      @(posedge clk_i); #1;
      n++;
    end
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_res"}, result_o, exp);
    @(posedge clk_i); #1;
    check({tag, "_rdy_drop"}, {31'b0, ready_o}, 32'd0);
    check({tag, "_busy_drop"}, {31'b0, busy_o}, 32'd0);
    check({tag, "_hold"}, result_o, exp);
  endtask

  initial begin
    int seen_ready;
    int first_t;
    int second_t;
    rst_i = 1'b1; start_i = 1'b0; op_i = 2'b00; dividend_i = '0; divisor_i = '0; annul_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_result", result_o, 32'd0);
    check("rst_ready", {31'b0, ready_o}, 32'd0);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Latency counts edges after the accept edge; 32 means ready_o is visible in cycle T+33.
    run_div("div_100_7", 2'b00, 32'd100, 32'd7, 32'd14, 32);
    run_div("rem_m100_7", 2'b10, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32);
    run_div("remu_m100_7", 2'b11, 32'hFFFF_FF9C, 32'd7, 32'd2, 32);
    run_div("divu_m100_7", 2'b01, 32'hFFFF_FF9C, 32'd7, 32'h2492_4916, 32);
    run_div("divu_5_0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    run_div("rem_5_0", 2'b10, 32'd5, 32'd0, 32'd5, 0);
    run_div("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32);
    run_div("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32);
    run_div("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32);
    run_div("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32);
    run_div("div_7_m2", 2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32);
    run_div("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32);

    // Annul together with start in IDLE: nothing accepted.
    start_i = 1'b1; annul_i = 1'b1; op_i = 2'b00; dividend_i = 32'd50; divisor_i = 32'd5;
    @(posedge clk_i); #1;
    check("annul_prio_busy", {31'b0, busy_o}, 32'd0);
    annul_i = 1'b0; start_i = 1'b0;

    // Annul part-way through ON: no ready pulse, back to IDLE.
    start_i = 1'b1; op_i = 2'b00; dividend_i = 32'd100; divisor_i = 32'd7;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    seen_ready = 0;
    repeat (10) begin
      @(posedge clk_i); #1;
      if (ready_o) seen_ready++;
    end
    check("annul_busy_on", {31'b0, busy_o}, 32'd1);
    annul_i = 1'b1;
    @(posedge clk_i); #1;
    annul_i = 1'b0;
    check("annul_idle", {31'b0, busy_o}, 32'd0);
    check("annul_no_ready", {31'b0, ready_o}, 32'd0);
    check("annul_result_held", result_o, 32'd1);
    repeat (30) begin
      @(posedge clk_i); #1;
      if (ready_o) seen_ready++;
    end
    check("annul_no_pulse", seen_ready, 32'd0);
    run_div("div_9_3", 2'b00, 32'd9, 32'd3, 32'd3, 32);

    // Asynchronous reset mid-ON, asserted between edges.
    start_i = 1'b1; op_i = 2'b00; dividend_i = 32'd1000; divisor_i = 32'd10;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #3;
    rst_i = 1'b1;
    #1;
    check("arst_busy", {31'b0, busy_o}, 32'd0);
    check("arst_ready", {31'b0, ready_o}, 32'd0);
    check("arst_result", result_o, 32'd0);
    #3;
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // start_i held high across two divides: ready pulses 34 edges apart.
    start_i = 1'b1; op_i = 2'b00; dividend_i = 32'd9; divisor_i = 32'd3;
    first_t = -1; second_t = -1;
    for (int t = 1; t <= 100 && second_t < 0; t++) begin
      @(posedge clk_i); #1;
      if (ready_o) begin
        if (first_t < 0) first_t = t;
        else second_t = t;
        check($sformatf("b2b_res_%0d", t), result_o, 32'd3);
      end
    end
    start_i = 1'b0;
    check("b2b_first_lat", first_t, 32'd33);
    check("b2b_spacing", second_t - first_t, 32'd34);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
